fifo_wr_ctrl: RTL and testbench

FIFO_WR_CTRL -- requirements
Module: fifo_wr_ctrl

---
 rtl/fifo_wr_ctrl.sv | 126 ++++++++++++
 tb/tb_fifo_wr_ctrl.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_wr_ctrl.sv
// FIFO write-side burst controller: waits for an empty FIFO, settles, then
// streams an incrementing data pattern until full, MAX_BURST or disable.
module fifo_wr_ctrl #(
  parameter int DATA_W     = 8,
  parameter int SETTLE_CYC = 3,
  parameter int MAX_BURST  = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_enable,
  input  logic              fifo_empty_flag,
  input  logic              fifo_full_flag,
  output logic              fifo_wr_flag,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic [7:0]        burst_cnt,
  output logic              burst_done,
  output logic              busy
);

  localparam int unsigned SET_W       = (SETTLE_CYC < 2) ? 1 : $clog2(SETTLE_CYC + 1);
  localparam int unsigned SETTLE_LAST = (SETTLE_CYC > 0) ? SETTLE_CYC - 1 : 0;
  localparam logic [7:0]  MAX_B       = 8'(MAX_BURST);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    WRITE  = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t              state_q, state_d;
  logic [SET_W-1:0]    settle_q, settle_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [7:0]          bcnt_q, bcnt_d;
  logic                wr_flag_d;
  logic [DATA_W-1:0]   wr_data_d;
  logic                done_d;
  logic                busy_d;
  logic                issue_write;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      settle_q     <= '0;
      data_q       <= '0;
      bcnt_q       <= '0;
      fifo_wr_flag <= 1'b0;
      fifo_wr_data <= '0;
      burst_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      state_q      <= state_d;
      settle_q     <= settle_d;
      data_q       <= data_d;
      bcnt_q       <= bcnt_d;
      fifo_wr_flag <= wr_flag_d;
      fifo_wr_data <= wr_data_d;
      burst_done   <= done_d;
      busy         <= busy_d;
    end
  end

  assign burst_cnt = bcnt_q;

  // Write decisions are made one edge ahead so the registered strobe lands
  // in the first WRITE cycle and stops the cycle after full/limit/disable.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    data_d      = data_q;
    bcnt_d      = bcnt_q;
    wr_data_d   = fifo_wr_data;
    issue_write = 1'b0;

    case (state_q)
      IDLE: begin
        if (wr_enable && fifo_empty_flag && !fifo_full_flag) begin
          state_d  = SETTLE;
          settle_d = '0;
          bcnt_d   = '0;
          data_d   = '0;
        end
      end
      SETTLE: begin
        if (fifo_full_flag) begin
          state_d = DONE;
        end else if (settle_q == SET_W'(SETTLE_LAST)) begin
          state_d     = WRITE;
          issue_write = (bcnt_q < MAX_B);
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end
      WRITE: begin
        if (fifo_full_flag || !wr_enable || (bcnt_q >= MAX_B)) begin
          state_d = DONE;
        end else begin
          issue_write = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    wr_flag_d = issue_write;
    if (issue_write) begin
      wr_data_d = data_q;
      data_d    = data_q + DATA_W'(1);
      bcnt_d    = (bcnt_q < MAX_B) ? bcnt_q + 8'd1 : MAX_B;
    end

    done_d = (state_d == DONE);
    busy_d = (state_d != IDLE);
  end

  a_wr_only_in_write: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_wr_flag |-> (state_q == WRITE));

  a_cnt_saturates: assert property (@(posedge clk) disable iff (!rst_n)
    bcnt_q <= MAX_B);

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Scoreboard bench for fifo_wr_ctrl: three instances (default, MAX_BURST=4,
// DATA_W=4/MAX_BURST=20) driven by directed vectors with hand-computed data.
module tb_fifo_wr_ctrl;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic en [3];
  logic emp [3];
  logic ful [3];

  logic       wf0, wf1, wf2;
  logic [7:0] wd0, wd1;
  logic [3:0] wd2;
  logic [7:0] bc0, bc1, bc2;
  logic       bd0, bd1, bd2;
  logic       by0, by1, by2;

  logic       wf [3];
  logic [7:0] wd [3];
  logic [7:0] bc [3];
  logic       bd [3];
  logic       by [3];

  fifo_wr_ctrl #(.DATA_W(8), .SETTLE_CYC(3), .MAX_BURST(255)) u_def (
    .clk(clk), .rst_n(rst_n), .wr_enable(en[0]), .fifo_empty_flag(emp[0]),
    .fifo_full_flag(ful[0]), .fifo_wr_flag(wf0), .fifo_wr_data(wd0),
    .burst_cnt(bc0), .burst_done(bd0), .busy(by0));

  fifo_wr_ctrl #(.DATA_W(8), .SETTLE_CYC(3), .MAX_BURST(4)) u_m4 (
    .clk(clk), .rst_n(rst_n), .wr_enable(en[1]), .fifo_empty_flag(emp[1]),
    .fifo_full_flag(ful[1]), .fifo_wr_flag(wf1), .fifo_wr_data(wd1),
    .burst_cnt(bc1), .burst_done(bd1), .busy(by1));

  fifo_wr_ctrl #(.DATA_W(4), .SETTLE_CYC(3), .MAX_BURST(20)) u_w4 (
    .clk(clk), .rst_n(rst_n), .wr_enable(en[2]), .fifo_empty_flag(emp[2]),
    .fifo_full_flag(ful[2]), .fifo_wr_flag(wf2), .fifo_wr_data(wd2),
    .burst_cnt(bc2), .burst_done(bd2), .busy(by2));

  always_comb begin
    wf[0] = wf0; wf[1] = wf1; wf[2] = wf2;
    wd[0] = wd0; wd[1] = wd1; wd[2] = {4'b0000, wd2};
    bc[0] = bc0; bc[1] = bc1; bc[2] = bc2;
    bd[0] = bd0; bd[1] = bd1; bd[2] = bd2;
    by[0] = by0; by[1] = by1; by[2] = by2;
  end

  int n_vec = 0;
  int n_err = 0;
  int q0[$];
  int q1[$];
  int q2[$];
  int wr_cnt [3] = '{0, 0, 0};
  int done_cnt [3] = '{0, 0, 0};

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic push(input int i, input int v);
    case (i)
      0: q0.push_back(v);
      1: q1.push_back(v);
      default: q2.push_back(v);
    endcase
  endtask

  function automatic int q_size(input int i);
    case (i)
      0: return q0.size();
      1: return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic check_write(input int i, input int act);
    int e;
    if (q_size(i) == 0) begin
      n_vec++;
      n_err++;
      $display("FAIL wr_unexpected[%0d]: got data %0d expected no write", i, act);
    end else begin
      case (i)
        0: e = q0.pop_front();
        1: e = q1.pop_front();
        default: e = q2.pop_front();
      endcase
      chk($sformatf("wr_data[%0d]", i), act, e);
    end
  endtask

  // Monitor: consumes every presented write and counts burst_done pulses.
  always @(posedge clk) begin
    #1;
    for (int i = 0; i < 3; i++) begin
      if (wf[i]) begin
        wr_cnt[i]++;
        check_write(i, int'(wd[i]));
      end
      if (bd[i]) done_cnt[i]++;
    end
  end

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  task automatic wait_writes(input int i, input int target);
    int t = 0;
    while (wr_cnt[i] < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (wr_cnt[i] < target) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout_writes[%0d]: got %0d expected %0d", i, wr_cnt[i], target);
    end
  endtask

  task automatic wait_done(input int i, input int target);
    int t = 0;
    while (done_cnt[i] < target && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (done_cnt[i] < target) begin
      n_vec++;
      n_err++;
      $display("FAIL timeout_done[%0d]: got %0d expected %0d", i, done_cnt[i], target);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int b, d, lat;
    for (int i = 0; i < 3; i++) begin
      en[i] = 1'b0; emp[i] = 1'b0; ful[i] = 1'b0;
    end

    // Reset state
    #1 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("rst_wr_flag[%0d]", i), int'(wf[i]), 0);
      chk($sformatf("rst_wr_data[%0d]", i), int'(wd[i]), 0);
      chk($sformatf("rst_burst_cnt[%0d]", i), int'(bc[i]), 0);
      chk($sformatf("rst_burst_done[%0d]", i), int'(bd[i]), 0);
      chk($sformatf("rst_busy[%0d]", i), int'(by[i]), 0);
    end
    cycles(2);
    rst_n = 1'b1;
    cycles(2);

    // Basic fill: 3 settle cycles, words 0..15, full during word 15
    b = wr_cnt[0]; d = done_cnt[0];
    for (int k = 0; k < 16; k++) push(0, k);
    en[0] = 1'b1; emp[0] = 1'b1;
    lat = 0;
    while (wr_cnt[0] == b && lat < 50) begin
      @(negedge clk);
      lat++;
    end
    chk("fill_first_write_lat", lat, 4);
    wait_writes(0, b + 16);
    chk("fill_last_flag", int'(wf[0]), 1);
    ful[0] = 1'b1;
    @(negedge clk);
    chk("fill_stop_flag", int'(wf[0]), 0);
    chk("fill_done_pulse", int'(bd[0]), 1);
    chk("fill_busy_in_done", int'(by[0]), 1);
    en[0] = 1'b0; emp[0] = 1'b0; ful[0] = 1'b0;
    cycles(2);
    chk("fill_burst_cnt", int'(bc[0]), 16);
    chk("fill_done_count", done_cnt[0], d + 1);
    chk("fill_busy_idle", int'(by[0]), 0);
    chk("fill_q_drained", q_size(0), 0);

    // MAX_BURST=4 with never-full FIFO
    b = wr_cnt[1]; d = done_cnt[1];
    for (int k = 0; k < 4; k++) push(1, k);
    en[1] = 1'b1; emp[1] = 1'b1;
    wait_done(1, d + 1);
    en[1] = 1'b0; emp[1] = 1'b0;
    cycles(4);
    chk("max4_burst_cnt", int'(bc[1]), 4);
    chk("max4_writes", wr_cnt[1] - b, 4);
    chk("max4_done_count", done_cnt[1], d + 1);
    chk("max4_busy_idle", int'(by[1]), 0);

    // Full during SETTLE: no writes, burst_cnt cleared at start
    b = wr_cnt[0]; d = done_cnt[0];
    en[0] = 1'b1; emp[0] = 1'b1;
    @(negedge clk);
    chk("settle_busy", int'(by[0]), 1);
    chk("settle_cnt_cleared", int'(bc[0]), 0);
    ful[0] = 1'b1;
    wait_done(0, d + 1);
    en[0] = 1'b0; emp[0] = 1'b0; ful[0] = 1'b0;
    cycles(2);
    chk("settle_full_burst_cnt", int'(bc[0]), 0);
    chk("settle_full_writes", wr_cnt[0] - b, 0);
    chk("settle_full_done_count", done_cnt[0], d + 1);

    // wr_enable dropped during the 5th write
    b = wr_cnt[0];
    for (int k = 0; k < 5; k++) push(0, k);
    en[0] = 1'b1; emp[0] = 1'b1;
    wait_writes(0, b + 5);
    en[0] = 1'b0; emp[0] = 1'b0;
    @(negedge clk);
    chk("drop_no_6th", int'(wf[0]), 0);
    @(negedge clk);
    chk("drop_idle_2cyc", int'(by[0]), 0);
    cycles(2);
    chk("drop_burst_cnt", int'(bc[0]), 5);
    chk("drop_writes", wr_cnt[0] - b, 5);

    // Reset mid-WRITE, then require a fresh empty before writing
    b = wr_cnt[0];
    for (int k = 0; k < 3; k++) push(0, k);
    en[0] = 1'b1; emp[0] = 1'b1;
    wait_writes(0, b + 3);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_wr_flag", int'(wf[0]), 0);
    chk("rst_mid_wr_data", int'(wd[0]), 0);
    chk("rst_mid_burst_cnt", int'(bc[0]), 0);
    chk("rst_mid_busy", int'(by[0]), 0);
    emp[0] = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    cycles(5);
    chk("rst_wait_busy", int'(by[0]), 0);
    chk("rst_wait_writes", wr_cnt[0] - b, 3);
    push(0, 0); push(0, 1);
    emp[0] = 1'b1;
    wait_writes(0, b + 5);
    ful[0] = 1'b1;
    @(negedge clk);
    en[0] = 1'b0; emp[0] = 1'b0; ful[0] = 1'b0;
    cycles(2);
    chk("rst_resume_burst_cnt", int'(bc[0]), 2);

    // Empty and full together: no start
    b = wr_cnt[0]; d = done_cnt[0];
    en[0] = 1'b1; emp[0] = 1'b1; ful[0] = 1'b1;
    cycles(4);
    chk("illegal_busy", int'(by[0]), 0);
    chk("illegal_writes", wr_cnt[0] - b, 0);
    chk("illegal_done_count", done_cnt[0], d);
    en[0] = 1'b0; emp[0] = 1'b0; ful[0] = 1'b0;
    cycles(2);

    // DATA_W=4, MAX_BURST=20: data wraps 15->0 without a gap
    b = wr_cnt[2]; d = done_cnt[2];
    for (int k = 0; k < 20; k++) push(2, k % 16);
    en[2] = 1'b1; emp[2] = 1'b1;
    wait_writes(2, b + 1);
    for (int k = 1; k < 20; k++) begin
      @(negedge clk);
      chk($sformatf("wrap_no_gap_%0d", k), int'(wf[2]), 1);
    end
    @(negedge clk);
    chk("wrap_stop_at_max", int'(wf[2]), 0);
    en[2] = 1'b0; emp[2] = 1'b0;
    cycles(2);
    chk("wrap_burst_cnt", int'(bc[2]), 20);
    chk("wrap_done_count", done_cnt[2], d + 1);

    cycles(2);
    chk("q0_drained", q_size(0), 0);
    chk("q1_drained", q_size(1), 0);
    chk("q2_drained", q_size(2), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
